// File: rtl/mmio_ctrl_if.sv
// Data-memory port between the single-cycle core and mmio_ctrl.
// Reads are combinational, so readdata follows addr within the same cycle.
interface mmio_ctrl_if;
  logic        memwrite;
  logic        memread;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite, memread, be, addr, writedata,
    input  readdata
  );

  modport slave (
    input  memwrite, memread, be, addr, writedata,
    output readdata
  );
endinterface

// File: rtl/mmio_ctrl.sv
// Data RAM with byte-enable writes plus a decoded I/O window: hex, LEDs,
// synchronised switches and a prescaled compare-match timer with interrupt.
module mmio_ctrl #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned HEX_W     = 16,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16,
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned IO_BASE   = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  mmio_ctrl_if.slave       bus,
  input  logic [SW_W-1:0]  sw,
  output logic [HEX_W-1:0] hex,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [31:0]      mem_q [MEM_WORDS];
  logic [HEX_W-1:0] hex_q;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [31:0]      tcnt_q, tcnt_d;
  logic [31:0]      tcmp_q;
  logic             en_q, autoclr_q, irqen_q;
  logic             match_q, match_d;
  logic             irq_q;

  logic [31:0] io_off;
  logic        io_hit, ram_hit, io_we, tick, match_set;
  logic        wr_hex, wr_led, wr_tcnt, wr_tcmp, wr_ctrl;
  logic [AW-1:0] ram_idx;
  logic        unused_memread;

  assign unused_memread = bus.memread;

  // I/O window takes priority over the RAM range it overlaps.
  assign io_off  = bus.addr - 32'(IO_BASE);
  assign io_hit  = (bus.addr >= 32'(IO_BASE)) && (io_off < 32'd6);
  assign ram_hit = !io_hit && (bus.addr < 32'(MEM_WORDS));
  assign ram_idx = bus.addr[AW-1:0];
  assign io_we   = bus.memwrite && io_hit;

  assign wr_hex  = io_we && (io_off[2:0] == 3'd0);
  assign wr_led  = io_we && (io_off[2:0] == 3'd1);
  assign wr_tcnt = io_we && (io_off[2:0] == 3'd3);
  assign wr_tcmp = io_we && (io_off[2:0] == 3'd4);
  assign wr_ctrl = io_we && (io_off[2:0] == 3'd5);

  assign tick = en_q && (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d     = pre_q + PW'(1);
    tcnt_d    = tcnt_q;
    match_set = 1'b0;
    if (!en_q || tick) begin
      pre_d = '0;
    end
    if (tick) begin
      if (tcnt_q == tcmp_q) begin
        match_set = 1'b1;
        tcnt_d    = autoclr_q ? 32'd0 : tcnt_q + 32'd1;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
    if (wr_tcnt) begin
      tcnt_d = bus.writedata;
    end
    match_d = match_q;
    if (wr_ctrl && bus.writedata[2]) begin
      match_d = 1'b0;
    end
    // A match in the same cycle as a clear must not be lost.
    if (match_set) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q     <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      pre_q     <= '0;
      tcnt_q    <= '0;
      tcmp_q    <= '0;
      en_q      <= 1'b0;
      autoclr_q <= 1'b0;
      irqen_q   <= 1'b0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      pre_q     <= pre_d;
      tcnt_q    <= tcnt_d;
      match_q   <= match_d;
      irq_q     <= match_q && irqen_q;
      if (wr_hex)  hex_q  <= bus.writedata[HEX_W-1:0];
      if (wr_led)  led_q  <= bus.writedata[LED_W-1:0];
      if (wr_tcmp) tcmp_q <= bus.writedata;
      if (wr_ctrl) begin
        en_q      <= bus.writedata[0];
        autoclr_q <= bus.writedata[1];
        irqen_q   <= bus.writedata[3];
      end
    end
  end

  // RAM is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (bus.memwrite && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) mem_q[ram_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    if (io_hit) begin
      unique case (io_off[2:0])
        3'd0:    bus.readdata = 32'(hex_q);
        3'd1:    bus.readdata = 32'(led_q);
        3'd2:    bus.readdata = 32'(sw_sync_q);
        3'd3:    bus.readdata = tcnt_q;
        3'd4:    bus.readdata = tcmp_q;
        3'd5:    bus.readdata = {28'd0, irqen_q, match_q, autoclr_q, en_q};
        default: bus.readdata = 32'd0;
      endcase
    end else if (ram_hit) begin
      bus.readdata = mem_q[ram_idx];
    end
  end

  assign hex = hex_q;
  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with PRESCALE=4 so timer ticks land every 4 clocks.
module tb_mmio_ctrl;
  localparam int unsigned IOB = 2000;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [15:0] hex;
  logic [15:0] led;
  logic        irq;
  int          checks;
  int          errors;

  mmio_ctrl_if bus ();

  mmio_ctrl #(
    .MEM_WORDS(4096),
    .HEX_W    (16),
    .LED_W    (16),
    .SW_W     (16),
    .PRESCALE (4),
    .IO_BASE  (IOB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .sw   (sw),
    .hex  (hex),
    .led  (led),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.addr      = a;
    bus.writedata = d;
    bus.be        = b;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr    = a;
    bus.memread = 1'b1;
    #1;
    d           = bus.readdata;
    bus.memread = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (hex !== 16'h0) begin errors++; $display("FAIL reset_hex got %h exp 0000", hex); end
    checks++;
    if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", led); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    for (int i = 0; i < 6; i++) begin
      bus_read(IOB + i, rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_io%0d got %h exp 00000000", i, rd);
      end
    end
  endtask

  task automatic test_ram_bytes();
    logic [31:0] rd;
    bus_write(32'd10, 32'hAABBCCDD, 4'b1111);
    bus_write(32'd10, 32'h11223344, 4'b0101);
    bus_read(32'd10, rd);
    checks++;
    if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL ram_be got %h exp AA22CC44", rd); end
    bus_write(32'd10, 32'hFFFFFFFF, 4'b0000);
    bus_read(32'd10, rd);
    checks++;
    if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL ram_be0 got %h exp AA22CC44", rd); end
    // 5000 mod 4096 = 904: a possible alias target
    bus_write(32'd904, 32'h12345678, 4'b1111);
    bus_write(32'd5000, 32'hDEADBEEF, 4'b1111);
    bus_read(32'd5000, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp 00000000", rd); end
    bus_read(32'd904, rd);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL no_alias got %h exp 12345678", rd); end
  endtask

  task automatic test_io();
    logic [31:0] rd;
    bus_write(IOB, 32'h0001BEEF, 4'b0000);
    checks++;
    if (hex !== 16'hBEEF) begin errors++; $display("FAIL hex_out got %h exp BEEF", hex); end
    bus_read(IOB, rd);
    checks++;
    if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL hex_rd got %h exp 0000BEEF", rd); end
    bus_write(IOB + 1, 32'h00005A5A, 4'b1111);
    checks++;
    if (led !== 16'h5A5A) begin errors++; $display("FAIL led_out got %h exp 5A5A", led); end
    bus_read(IOB + 1, rd);
    checks++;
    if (rd !== 32'h00005A5A) begin errors++; $display("FAIL led_rd got %h exp 00005A5A", rd); end
    bus_write(IOB + 2, 32'h0000FFFF, 4'b1111);
    bus_read(IOB + 2, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_ro got %h exp 00000000", rd); end
  endtask

  task automatic test_switch_sync();
    logic [31:0] rd;
    sw = 16'h00F0;
    bus_read(IOB + 2, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_e0 got %h exp 00000000", rd); end
    @(posedge clk);
    #1;
    bus_read(IOB + 2, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_e1 got %h exp 00000000", rd); end
    @(posedge clk);
    #1;
    bus_read(IOB + 2, rd);
    checks++;
    if (rd !== 32'h000000F0) begin errors++; $display("FAIL sw_e2 got %h exp 000000F0", rd); end
  endtask

  // Enable edge is E0; ticks land on E4, E8, E12, E16 (match) and so on.
  task automatic test_timer_match();
    logic [31:0] rd;
    bus_write(IOB + 4, 32'd3, 4'b1111);
    bus_write(IOB + 5, 32'h0000000B, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    bus_read(IOB + 3, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL tcnt_e3 got %0d exp 0", rd); end
    for (int k = 1; k <= 3; k++) begin
      repeat ((k == 1) ? 1 : 4) @(posedge clk);
      #1;
      bus_read(IOB + 3, rd);
      checks++;
      if (rd !== 32'(k)) begin errors++; $display("FAIL tcnt_tick%0d got %0d exp %0d", k, rd, k); end
    end
    bus_read(IOB + 5, rd);
    checks++;
    if (rd !== 32'hB) begin errors++; $display("FAIL tctrl_pre got %h exp 0000000B", rd); end
    repeat (4) @(posedge clk);
    #1;
    bus_read(IOB + 3, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL tcnt_autoclr got %0d exp 0", rd); end
    bus_read(IOB + 5, rd);
    checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL match_set got %h exp 0000000F", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    bus_write(IOB + 5, 32'h0000000F, 4'b1111);
    bus_read(IOB + 5, rd);
    checks++;
    if (rd !== 32'hB) begin errors++; $display("FAIL match_w1c got %h exp 0000000B", rd); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
  endtask

  // Entered in the cycle whose prescaler phase is 3, i.e. a tick cycle.
  task automatic test_collision();
    logic [31:0] rd;
    bus_write(IOB + 3, 32'd100, 4'b1111);
    bus_read(IOB + 3, rd);
    checks++;
    if (rd !== 32'd100) begin errors++; $display("FAIL tcnt_cpu_wins got %0d exp 100", rd); end
    repeat (4) @(posedge clk);
    #1;
    bus_read(IOB + 3, rd);
    checks++;
    if (rd !== 32'd101) begin errors++; $display("FAIL tcnt_after got %0d exp 101", rd); end
    bus_write(IOB + 4, 32'd101, 4'b1111);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_second got %b exp 1", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    #2;
    rst_n = 1'b0;
    #1;
    bus_read(IOB + 3, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rst_tcnt got %0d exp 0", rd); end
    bus_read(IOB + 5, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rst_tctrl got %h exp 00000000", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++;
    if (hex !== 16'h0) begin errors++; $display("FAIL rst_hex got %h exp 0000", hex); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_read(32'd10, rd);
    checks++;
    if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL ram_keep got %h exp AA22CC44", rd); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    sw            = '0;
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.be        = 4'b0000;
    bus.addr      = '0;
    bus.writedata = '0;
    test_reset();
    test_ram_bytes();
    test_io();
    test_switch_sync();
    test_timer_match();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
